// File: rtl/cable_seq_ctrl.sv
// Cable sequence controller: arms on flag & detect, waits for the accumulator,
// then runs a timed LINE phase followed by a timed GEAR phase. A ready timeout
// parks the controller in FAULT until it is acknowledged. Completed sequences
// are counted in a saturating counter.
module cable_seq_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 1000,
  parameter int CYC_W    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flag,
  input  logic             detect,
  input  logic             ready,
  input  logic             abort,
  input  logic             clr_fault,
  input  logic [CNT_W-1:0] line_cycles,
  input  logic [CNT_W-1:0] gear_cycles,
  output logic             open,
  output logic             en_sensor,
  output logic             en_acc,
  output logic             en_clamp,
  output logic             line_active,
  output logic             gear_active,
  output logic             busy,
  output logic             fault,
  output logic             done,
  output logic [CYC_W-1:0] cycle_count
);

  // The wait counter only needs to reach WAIT_MAX-1: the last ARM cycle is
  // recognised by its value rather than by counting past it.
  localparam int                WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_LINE  = 3'd2,
    S_GEAR  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               done_q, done_d;
  logic               state_ok;

  // A zero duration still occupies its phase for one cycle.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Next-state, phase/wait counters and completion bookkeeping.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    phase_d = phase_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flag && detect) begin
          state_d = S_ARM;
          wait_d  = '0;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ready) begin
          state_d = S_LINE;
          phase_d = at_least_one(line_cycles);
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_LINE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (phase_q <= CNT_W'(1)) begin
          state_d = S_GEAR;
          phase_d = at_least_one(gear_cycles);
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      S_GEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (phase_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      S_FAULT: begin
        if (clr_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with its counters; reset abandons any sequence in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      phase_q <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
    end
  end

  // Moore decode of the state register; an illegal encoding drives everything low.
  always_comb begin
    open        = 1'b0;
    en_sensor   = 1'b0;
    en_acc      = 1'b0;
    en_clamp    = 1'b0;
    line_active = 1'b0;
    gear_active = 1'b0;
    busy        = 1'b0;
    fault       = 1'b0;
    state_ok    = 1'b1;
    case (state_q)
      S_IDLE: begin
        open      = 1'b1;
        en_sensor = 1'b1;
      end
      S_ARM: begin
        open      = 1'b1;
        en_sensor = 1'b1;
        en_acc    = 1'b1;
        busy      = 1'b1;
      end
      S_LINE: begin
        en_clamp    = 1'b1;
        line_active = 1'b1;
        busy        = 1'b1;
      end
      S_GEAR: begin
        open        = 1'b1;
        en_clamp    = 1'b1;
        gear_active = 1'b1;
        busy        = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: state_ok = 1'b0;
    endcase
    done        = done_q & state_ok;
    cycle_count = state_ok ? cyc_q : '0;
  end

endmodule

// File: tb/tb_cable_seq_ctrl.sv
// Scoreboard bench for cable_seq_ctrl: a behavioural model predicts the output
// vector for each clock, the prediction is queued, and the negedge checker
// compares it with the DUT.
module tb_cable_seq_ctrl;

  localparam int CNT_W    = 8;
  localparam int WAIT_MAX = 8;
  localparam int CYC_W    = 2;
  localparam int CNT_MAX  = (1 << CYC_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_LINE  = 2;
  localparam int M_GEAR  = 3;
  localparam int M_FAULT = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             flag = 1'b0;
  logic             detect = 1'b0;
  logic             ready = 1'b0;
  logic             abort = 1'b0;
  logic             clr_fault = 1'b0;
  logic [CNT_W-1:0] line_cycles = '0;
  logic [CNT_W-1:0] gear_cycles = '0;
  logic             open, en_sensor, en_acc, en_clamp;
  logic             line_active, gear_active, busy, fault, done;
  logic [CYC_W-1:0] cycle_count;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  int m_state = M_IDLE;
  int m_wait  = 0;
  int m_left  = 0;
  int m_cnt   = 0;
  bit m_done  = 1'b0;

  cable_seq_ctrl #(
    .CNT_W(CNT_W),
    .WAIT_MAX(WAIT_MAX),
    .CYC_W(CYC_W)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .flag(flag),
    .detect(detect),
    .ready(ready),
    .abort(abort),
    .clr_fault(clr_fault),
    .line_cycles(line_cycles),
    .gear_cycles(gear_cycles),
    .open(open),
    .en_sensor(en_sensor),
    .en_acc(en_acc),
    .en_clamp(en_clamp),
    .line_active(line_active),
    .gear_active(gear_active),
    .busy(busy),
    .fault(fault),
    .done(done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {open,en_sensor,en_acc,en_clamp,line_active,gear_active,busy,fault,done,cycle_count}
  function automatic logic [10:0] dut_vec();
    return {open, en_sensor, en_acc, en_clamp, line_active, gear_active,
            busy, fault, done, cycle_count};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [7:0]  f;
    logic [31:0] c;
    case (m_state)
      M_IDLE:  f = 8'b1100_0000;
      M_ARM:   f = 8'b1110_0010;
      M_LINE:  f = 8'b0001_1010;
      M_GEAR:  f = 8'b1001_0110;
      default: f = 8'b0000_0001;
    endcase
    c = m_cnt;
    return {f, m_done, c[CYC_W-1:0]};
  endfunction

  // Advance the reference model by one clock using the inputs as currently driven.
  task automatic model_step();
    m_done = 1'b0;
    if (!resetn) begin
      m_state = M_IDLE;
      m_wait  = 0;
      m_left  = 0;
      m_cnt   = 0;
      return;
    end
    case (m_state)
      M_IDLE: if (flag && detect) begin
        m_state = M_ARM;
        m_wait  = 0;
      end
      M_ARM: begin
        if (abort) m_state = M_IDLE;
        else if (ready) begin
          m_state = M_LINE;
          m_left  = (line_cycles == 0) ? 1 : int'(line_cycles);
        end else begin
          m_wait++;
          if (m_wait >= WAIT_MAX) m_state = M_FAULT;
        end
      end
      M_LINE: begin
        if (abort) m_state = M_IDLE;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_state = M_GEAR;
            m_left  = (gear_cycles == 0) ? 1 : int'(gear_cycles);
          end
        end
      end
      M_GEAR: begin
        if (abort) m_state = M_IDLE;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_state = M_IDLE;
            m_done  = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
        end
      end
      default: if (clr_fault) m_state = M_IDLE;
    endcase
  endtask

  // One clock: predict, queue, then let the checker compare at the next negedge.
  task automatic cyc();
    model_step();
    exp_q.push_back(exp_vec());
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : scoreboard
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("outputs_state%0d", m_state), {21'b0, dut_vec()}, {21'b0, e});
    end
  end

  // Full sequence: trigger, ready raised in ARM cycle rd, then LINE/GEAR run out.
  task automatic run_seq(input int l, input int g, input int rd);
    line_cycles = CNT_W'(l);
    gear_cycles = CNT_W'(g);
    flag = 1'b1;
    detect = 1'b1;
    cyc();
    flag = 1'b0;
    detect = 1'b0;
    for (int i = 1; i < rd; i++) cyc();
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    line_cycles = 8'd77;
    for (int i = 0; i < ((l == 0) ? 1 : l); i++) cyc();
    gear_cycles = 8'd99;
    for (int i = 0; i < ((g == 0) ? 1 : g); i++) cyc();
    chk("seq_done_pulse", {31'b0, done}, 32'd1);
    cyc();
    chk("seq_done_clear", {31'b0, done}, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_outputs", {21'b0, dut_vec()}, {21'b0, 11'b110_0000_0000});
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();

    // Nominal sequence
    run_seq(5, 4, 3);
    chk("nominal_count", {30'b0, cycle_count}, 32'd1);

    // Abort in the third LINE cycle
    line_cycles = 8'd5;
    gear_cycles = 8'd4;
    flag = 1'b1;
    detect = 1'b1;
    cyc();
    flag = 1'b0;
    detect = 1'b0;
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    cyc();
    cyc();
    chk("abort_in_line", {31'b0, line_active}, 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_idle_open", {31'b0, open}, 32'd1);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    chk("abort_count", {30'b0, cycle_count}, 32'd1);
    cyc();

    // Ready timeout, abort ignored in FAULT, then acknowledge
    flag = 1'b1;
    detect = 1'b1;
    cyc();
    flag = 1'b0;
    detect = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) cyc();
    chk("timeout_fault", {31'b0, fault}, 32'd1);
    chk("timeout_open", {31'b0, open}, 32'd0);
    abort = 1'b1;
    cyc();
    cyc();
    abort = 1'b0;
    clr_fault = 1'b1;
    cyc();
    clr_fault = 1'b0;
    chk("clear_to_idle", {29'b0, open, en_sensor, fault}, 32'b110);
    clr_fault = 1'b1;
    cyc();
    clr_fault = 1'b0;

    // Ready in the final permitted ARM cycle
    run_seq(2, 2, WAIT_MAX);
    chk("boundary_no_fault", {31'b0, fault}, 32'd0);

    // Zero durations
    run_seq(0, 0, 1);

    // Two more completions: five in total, counter saturates
    run_seq(1, 1, 2);
    run_seq(3, 2, 1);
    chk("saturated_count", {30'b0, cycle_count}, 32'd3);

    // Reset pulse in the middle of GEAR
    line_cycles = 8'd1;
    gear_cycles = 8'd4;
    flag = 1'b1;
    detect = 1'b1;
    cyc();
    flag = 1'b0;
    detect = 1'b0;
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    cyc();
    cyc();
    chk("in_gear", {31'b0, gear_active}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("midgear_reset_outputs", {21'b0, dut_vec()}, {21'b0, 11'b110_0000_0000});
    cyc();
    resetn = 1'b1;
    cyc();
    chk("reset_count_zero", {30'b0, cycle_count}, 32'd0);
    chk("reset_no_done", {31'b0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cable_seq_ctrl.md
CABLE_SEQ_CTRL -- requirements
Module: cable_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of phase-duration inputs and of the internal phase counter.
REQ-002 SHALL have parameter WAIT_MAX, default 1000: maximum number of ARM cycles allowed without ready before a fault.
REQ-003 SHALL have parameter CYC_W, default 8: width of the completed-cycle counter.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port flag, input, 1: arming qualifier.
REQ-007 SHALL have port detect, input, 1: cable-present sensor.
REQ-008 SHALL have port ready, input, 1: accumulator ready.
REQ-009 SHALL have port abort, input, 1: synchronous abort request.
REQ-010 SHALL have port clr_fault, input, 1: fault acknowledge.
REQ-011 SHALL have port line_cycles, input, CNT_W: LINE phase duration in cycles.
REQ-012 SHALL have port gear_cycles, input, CNT_W: GEAR phase duration in cycles.
REQ-013 SHALL have outputs open, en_sensor, en_acc and en_clamp, each 1 bit: actuator enables.
REQ-014 SHALL have outputs line_active and gear_active, each 1 bit: phase indicators.
REQ-015 SHALL have outputs busy, fault and done, each 1 bit: status.
REQ-016 SHALL have output cycle_count, CYC_W: number of completed sequences.

Function
REQ-017 SHALL implement states IDLE, ARM, LINE, GEAR and FAULT in a single state register.
REQ-018 SHALL transition IDLE->ARM in the cycle after (flag & detect)=1; the wait counter clears on this transition.
REQ-019 SHALL, in ARM, transition to LINE when ready=1.
REQ-020 SHALL, in ARM, transition to FAULT when WAIT_MAX consecutive ARM cycles elapse with ready=0; if ready=1 in that final cycle, ready wins and the next state is LINE.
REQ-021 SHALL latch line_cycles on the ARM->LINE transition and remain in LINE for exactly max(line_cycles,1) cycles, then go to GEAR.
REQ-022 SHALL latch gear_cycles on the LINE->GEAR transition and remain in GEAR for exactly max(gear_cycles,1) cycles, then go to IDLE.
REQ-023 SHALL ignore changes to line_cycles and gear_cycles after their latch points.
REQ-024 SHALL, on GEAR->IDLE, pulse done high for exactly one cycle (the first IDLE cycle) and increment cycle_count, saturating at all-ones.
REQ-025 SHALL, when abort=1 in ARM, LINE or GEAR, go to IDLE next cycle; abort overrides every other transition and causes no done pulse and no count increment.
REQ-026 SHALL ignore abort in IDLE and FAULT.
REQ-027 SHALL stay in FAULT until clr_fault=1, then go to IDLE; clr_fault SHALL be ignored in all other states.
REQ-028 SHALL decode outputs from the state register (Moore) as follows:
- IDLE: open=1, en_sensor=1, all other enables and indicators 0.
- ARM: open=1, en_sensor=1, en_acc=1.
- LINE: open=0, en_clamp=1, line_active=1.
- GEAR: open=1, en_clamp=1, gear_active=1.
- FAULT: open=0, all enables 0, fault=1.
REQ-029 SHALL drive busy=1 in ARM, LINE and GEAR, and busy=0 in IDLE and FAULT.
REQ-030 SHALL treat any unreachable state encoding as IDLE on the next clock, with all outputs 0 while in it.

Reset
REQ-031 SHALL, while resetn=0, force state=IDLE, all counters=0, cycle_count=0, done=0, fault=0, busy=0, open=1 and en_sensor=1.
REQ-032 SHALL abandon any sequence in progress on resetn assertion mid-operation, with no done pulse and no count change.

Verification
REQ-033 Bench SHALL cover the nominal sequence:
- Stimulus: flag=detect=1 for 1 cycle; ready after 3 cycles; line_cycles=5; gear_cycles=4.
- Response: ARM for 3 cycles, LINE for 5, GEAR for 4; done pulses once; cycle_count=1.
REQ-034 Bench SHALL cover the ready timeout:
- Stimulus: WAIT_MAX=8; ready held 0.
- Response: FAULT entered after 8 ARM cycles with fault=1 and open=0; clr_fault -> IDLE.
REQ-035 Bench SHALL cover the timeout boundary:
- Stimulus: ready=1 exactly in the 8th ARM cycle.
- Response: next state LINE; fault stays 0.
REQ-036 Bench SHALL cover zero durations:
- Stimulus: line_cycles=0, gear_cycles=0.
- Response: LINE for 1 cycle, GEAR for 1 cycle; done pulses.
REQ-037 Bench SHALL cover abort:
- Stimulus: abort=1 in the 3rd LINE cycle.
- Response: IDLE next cycle; done=0; cycle_count unchanged.
REQ-038 Bench SHALL cover counter saturation and reset:
- Stimulus: CYC_W=2, run 5 sequences.
- Response: cycle_count=3.
- Stimulus: resetn pulse mid-GEAR.
- Response: state IDLE; cycle_count=0.
